// File: rtl/multicycle_controller.sv
// Control FSM for the shared-resource ARM multicycle datapath: decode, sequencing, NZCV and write gating.
// Optional: define ILLEGAL_TRAP_EN to trap Op=11 into a HALT state (otherwise Op=11 is a NOP).
module multicycle_controller #(
    parameter logic [3:0] INIT_FLAGS = 4'b0000,
    parameter logic [3:0] PC_REG     = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic       RegWrite,
    output logic [1:0] ALUControl,
    output logic       Halted
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        HALT   = 4'd10
    } state_t;

    typedef struct packed {
        logic [1:0] ctl;
        logic       arith;
    } dp_t;

    state_t     state, next_state;
    logic [3:0] flags;
    logic       condex_q;
    logic       cond_pass;
    logic       rd_is_pc;
    dp_t        dp;

    logic       pc_we, mem_we, ir_we, reg_we;

    function automatic logic condcheck(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'b0000: condcheck = z;
            4'b0001: condcheck = !z;
            4'b0010: condcheck = cf;
            4'b0011: condcheck = !cf;
            4'b0100: condcheck = n;
            4'b0101: condcheck = !n;
            4'b0110: condcheck = v;
            4'b0111: condcheck = !v;
            4'b1000: condcheck = cf & !z;
            4'b1001: condcheck = !cf | z;
            4'b1010: condcheck = (n == v);
            4'b1011: condcheck = (n != v);
            4'b1100: condcheck = !z & (n == v);
            4'b1101: condcheck = z | (n != v);
            4'b1110: condcheck = 1'b1;
            default: condcheck = 1'b0;
        endcase
    endfunction

    assign cond_pass = condcheck(Cond, flags);
    assign rd_is_pc  = (Rd == PC_REG);

    // Unrecognised DP encodings fall back to ADD, which also lets them update C/V.
    always_comb begin
        dp.ctl   = 2'b00;
        dp.arith = 1'b1;
        case (Funct[4:1])
            4'b0100: begin dp.ctl = 2'b00; dp.arith = 1'b1; end
            4'b0010: begin dp.ctl = 2'b01; dp.arith = 1'b1; end
            4'b0000: begin dp.ctl = 2'b10; dp.arith = 1'b0; end
            4'b1100: begin dp.ctl = 2'b11; dp.arith = 1'b0; end
            default: begin dp.ctl = 2'b00; dp.arith = 1'b1; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            flags    <= INIT_FLAGS;
            condex_q <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                condex_q <= cond_pass;
            if ((state == EXECR || state == EXECI) && condex_q && Funct[0]) begin
                flags[3:2] <= ALUFlags[3:2];
                if (dp.arith)
                    flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   next_state = Funct[5] ? EXECI : EXECR;
                    2'b01:   next_state = MEMADR;
                    2'b10:   next_state = BRANCH;
`ifdef ILLEGAL_TRAP_EN
                    default: next_state = HALT;
`else
                    default: next_state = FETCH;
`endif
                endcase
            end
            MEMADR: next_state = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state = MEMWB;
            EXECR:  next_state = ALUWB;
            EXECI:  next_state = ALUWB;
`ifdef ILLEGAL_TRAP_EN
            HALT:   next_state = HALT;
`endif
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        pc_we      = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        case (state)
            FETCH: begin
                ir_we     = 1'b1;
                pc_we     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD: begin
                ResultSrc = 2'b00;
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_we    = condex_q;
                pc_we     = condex_q & rd_is_pc;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_we = condex_q;
            end
            EXECR: ALUControl = dp.ctl;
            EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp.ctl;
            end
            ALUWB: begin
                reg_we = condex_q;
                pc_we  = condex_q & rd_is_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_we     = condex_q;
            end
            default: ;
        endcase
    end

    // Field-derived controls track the IR in every state.
    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01) & !Funct[0], (Op == 2'b10)};

    assign PCWrite  = pc_we  & !reset;
    assign MemWrite = mem_we & !reset;
    assign IRWrite  = ir_we  & !reset;
    assign RegWrite = reg_we & !reset;

`ifdef ILLEGAL_TRAP_EN
    assign Halted = (state == HALT) & !reset;
`else
    assign Halted = 1'b0;
`endif

endmodule
